// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the RV32I core.
// Issues one synchronous-read fetch per cycle, absorbs stalls and redirects, traps misaligned targets.
module fetch_stage #(
    parameter int unsigned        PC_W     = 9,
    parameter int unsigned        INST_W   = 32,
    parameter logic [PC_W-1:0]    RESET_PC = '0,
    parameter logic [INST_W-1:0]  NOP      = INST_W'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [PC_W-1:0]   target_i,
    output logic [PC_W-1:0]   imem_addr_o,
    output logic              imem_en_o,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic [PC_W-1:0]   if_id_pc_o,
    output logic [INST_W-1:0] if_id_inst_o,
    output logic              if_id_valid_o,
    output logic [PC_W-1:0]   pc_o,
    output logic              fault_o,
    output logic [PC_W-1:0]   fault_pc_o,
    output logic [31:0]       fetch_count_o
);

    localparam int unsigned  CNT_W   = 32;
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_f_pc;
    logic               r_f_valid;
    logic [PC_W-1:0]    r_id_pc;
    logic [INST_W-1:0]  r_id_inst;
    logic               r_id_valid;
    logic               r_fault;
    logic [PC_W-1:0]    r_fault_pc;
    logic [CNT_W-1:0]   r_fetch_count;

    logic               w_imem_en;
    logic               w_advance;
    logic               w_redirect;
    logic               w_fault_set;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-edge action select; flush outranks stall
    always_comb begin
        w_state_nxt = r_state;
        w_imem_en   = 1'b0;
        w_advance   = 1'b0;
        w_redirect  = 1'b0;
        w_fault_set = 1'b0;
        case (r_state)
            S_START: begin
                w_imem_en   = 1'b1;
                w_advance   = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_imem_en = flush_i | ~stall_i;
                if (flush_i) begin
                    if (target_i[1:0] != 2'b00) begin
                        w_fault_set = 1'b1;
                        w_state_nxt = S_FAULT;
                    end else begin
                        w_redirect = 1'b1;
                    end
                end else if (!stall_i) begin
                    w_advance = 1'b1;
                end
            end
            S_FAULT: begin
                w_imem_en = 1'b0;
            end
            default: begin
                w_state_nxt = S_START;
            end
        endcase
    end

    // PC, in-flight fetch tag and IF/ID register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_f_pc     <= '0;
            r_f_valid  <= 1'b0;
            r_id_pc    <= '0;
            r_id_inst  <= NOP;
            r_id_valid <= 1'b0;
        end else if (w_fault_set) begin
            r_f_valid  <= 1'b0;
            r_id_valid <= 1'b0;
            r_id_inst  <= NOP;
        end else if (w_redirect) begin
            r_pc       <= target_i;
            r_f_valid  <= 1'b0;
            r_id_valid <= 1'b0;
            r_id_inst  <= NOP;
        end else if (w_advance) begin
            r_id_pc    <= r_f_pc;
            r_id_inst  <= r_f_valid ? imem_rdata_i : NOP;
            r_id_valid <= r_f_valid;
            r_f_pc     <= r_pc;
            r_f_valid  <= 1'b1;
            r_pc       <= r_pc + PC_STEP;
        end
    end

    // Sticky misaligned-redirect record
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fault    <= 1'b0;
            r_fault_pc <= '0;
        end else if (w_fault_set) begin
            r_fault    <= 1'b1;
            r_fault_pc <= target_i;
        end
    end

    // Delivered-instruction counter: bumps only when IF/ID takes a real instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_count <= '0;
        end else if (w_advance && r_f_valid) begin
            r_fetch_count <= r_fetch_count + CNT_W'(1);
        end
    end

    assign imem_addr_o   = r_pc;
    assign pc_o          = r_pc;
    assign imem_en_o     = w_imem_en;
    assign if_id_pc_o    = r_id_pc;
    assign if_id_inst_o  = r_id_inst;
    assign if_id_valid_o = r_id_valid;
    assign fault_o       = r_fault;
    assign fault_pc_o    = r_fault_pc;
    assign fetch_count_o = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stall/flush
// traffic compared against an address-stream reference model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [8:0]  target_i = '0;
    logic [8:0]  imem_addr_o;
    logic        imem_en_o;
    logic [31:0] imem_rdata_i = '0;
    logic [8:0]  if_id_pc_o;
    logic [31:0] if_id_inst_o;
    logic        if_id_valid_o;
    logic [8:0]  pc_o;
    logic        fault_o;
    logic [8:0]  fault_pc_o;
    logic [31:0] fetch_count_o;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .target_i      (target_i),
        .imem_addr_o   (imem_addr_o),
        .imem_en_o     (imem_en_o),
        .imem_rdata_i  (imem_rdata_i),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_inst_o  (if_id_inst_o),
        .if_id_valid_o (if_id_valid_o),
        .pc_o          (pc_o),
        .fault_o       (fault_o),
        .fault_pc_o    (fault_pc_o),
        .fetch_count_o (fetch_count_o)
    );

    always #5 clk = ~clk;

    // Word k of instruction memory is 0x100 + k
    function automatic logic [31:0] mem_word(input logic [8:0] a);
        return 32'h100 + 32'(a[8:2]);
    endfunction

    always @(posedge clk) begin
        if (imem_en_o) imem_rdata_i <= mem_word(imem_addr_o);
    end

    // Reference model: next issue address, queue of issued-but-undelivered addresses, IF/ID view
    logic [8:0]  m_nxt;
    logic [8:0]  m_inflight[$];
    bit          m_started;
    bit          m_fault;
    bit          m_valid;
    logic [8:0]  m_id_pc;
    logic [8:0]  m_fault_pc;
    logic [31:0] m_count;

    function automatic logic [31:0] m_inst();
        return m_valid ? mem_word(m_id_pc) : NOP;
    endfunction

    task automatic model_reset();
        m_nxt      = 9'h000;
        m_inflight.delete();
        m_started  = 1'b0;
        m_fault    = 1'b0;
        m_valid    = 1'b0;
        m_id_pc    = 9'h000;
        m_fault_pc = 9'h000;
        m_count    = 32'd0;
    endtask

    task automatic model_advance();
        if (m_inflight.size() > 0) begin
            m_id_pc = m_inflight.pop_front();
            m_valid = 1'b1;
            m_count = m_count + 32'd1;
        end else begin
            m_valid = 1'b0;
        end
        m_inflight.push_back(m_nxt);
        m_nxt = m_nxt + 9'd4;
    endtask

    task automatic model_edge(input logic st, input logic fl, input logic [8:0] tg);
        if (m_fault) return;
        if (!m_started) begin
            m_started = 1'b1;
            model_advance();
        end else if (fl) begin
            m_inflight.delete();
            m_valid = 1'b0;
            if (tg[1:0] != 2'b00) begin
                m_fault    = 1'b1;
                m_fault_pc = tg;
            end else begin
                m_nxt = tg;
            end
        end else if (!st) begin
            model_advance();
        end
    endtask

    function automatic logic m_en(input logic st, input logic fl);
        if (m_fault) return 1'b0;
        if (!m_started) return 1'b1;
        return fl | ~st;
    endfunction

    task automatic drive_edge(input logic st, input logic fl, input logic [8:0] tg);
        stall_i  = st;
        flush_i  = fl;
        target_i = tg;
        @(posedge clk);
        model_edge(st, fl, tg);
        #1;
        stall_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_id_valid_o); end
        n_tests++; if (if_id_inst_o !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h want %h", if_id_inst_o, NOP); end
        n_tests++; if (if_id_pc_o !== 9'h000) begin n_fail++; $display("FAIL reset_id_pc: got %h want 000", if_id_pc_o); end
        n_tests++; if (pc_o !== 9'h000 || imem_addr_o !== 9'h000) begin n_fail++; $display("FAIL reset_pc: got %h/%h want 000", pc_o, imem_addr_o); end
        n_tests++; if (imem_en_o !== 1'b1) begin n_fail++; $display("FAIL reset_en: got %b want 1", imem_en_o); end
        n_tests++; if (fault_o !== 1'b0 || fault_pc_o !== 9'h000) begin n_fail++; $display("FAIL reset_fault: got %b/%h want 0/000", fault_o, fault_pc_o); end
        n_tests++; if (fetch_count_o !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fetch_count_o); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_startup();
        logic [8:0]  exp_pc[3]   = '{9'h000, 9'h004, 9'h008};
        logic [31:0] exp_inst[3] = '{32'h100, 32'h101, 32'h102};
        drive_edge(1'b0, 1'b0, 9'h000);
        n_tests++; if (if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL start_edge1_valid: got %b want 0", if_id_valid_o); end
        n_tests++; if (pc_o !== 9'h004) begin n_fail++; $display("FAIL start_edge1_pc: got %h want 004", pc_o); end
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b0, 1'b0, 9'h000);
            n_tests++;
            if (if_id_valid_o !== 1'b1 || if_id_pc_o !== exp_pc[i] || if_id_inst_o !== exp_inst[i]) begin
                n_fail++;
                $display("FAIL start_deliver%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         i, if_id_valid_o, if_id_pc_o, if_id_inst_o, exp_pc[i], exp_inst[i]);
            end
        end
        n_tests++; if (fetch_count_o !== 32'd3) begin n_fail++; $display("FAIL start_count: got %0d want 3", fetch_count_o); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            stall_i = 1'b1;
            #1;
            n_tests++; if (imem_en_o !== 1'b0) begin n_fail++; $display("FAIL stall_en%0d: got %b want 0", i, imem_en_o); end
            drive_edge(1'b1, 1'b0, 9'h000);
            n_tests++;
            if (if_id_pc_o !== 9'h008 || if_id_inst_o !== 32'h102 || pc_o !== 9'h010 || fetch_count_o !== 32'd3) begin
                n_fail++;
                $display("FAIL stall_frozen%0d: got pc=%h inst=%h pc_o=%h cnt=%0d want 008 102 010 3",
                         i, if_id_pc_o, if_id_inst_o, pc_o, fetch_count_o);
            end
        end
        drive_edge(1'b0, 1'b0, 9'h000);
        n_tests++;
        if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 9'h00C || if_id_inst_o !== 32'h103 || fetch_count_o !== 32'd4) begin
            n_fail++;
            $display("FAIL stall_resume: got v=%b pc=%h inst=%h cnt=%0d want 1 00c 103 4",
                     if_id_valid_o, if_id_pc_o, if_id_inst_o, fetch_count_o);
        end
    endtask

    task automatic test_flush_stall();
        stall_i  = 1'b1;
        flush_i  = 1'b1;
        target_i = 9'h040;
        #1;
        n_tests++; if (imem_en_o !== 1'b1) begin n_fail++; $display("FAIL flush_en: got %b want 1", imem_en_o); end
        drive_edge(1'b1, 1'b1, 9'h040);
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (if_id_valid_o !== 1'b0 || if_id_inst_o !== NOP) begin
                n_fail++;
                $display("FAIL flush_bubble%0d: got v=%b inst=%h want 0 %h", i, if_id_valid_o, if_id_inst_o, NOP);
            end
            drive_edge(1'b0, 1'b0, 9'h000);
        end
        n_tests++;
        if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 9'h040 || if_id_inst_o !== 32'h110 || pc_o !== 9'h048) begin
            n_fail++;
            $display("FAIL flush_target: got v=%b pc=%h inst=%h pc_o=%h want 1 040 110 048",
                     if_id_valid_o, if_id_pc_o, if_id_inst_o, pc_o);
        end
        n_tests++; if (fetch_count_o !== 32'd5) begin n_fail++; $display("FAIL flush_count: got %0d want 5", fetch_count_o); end
        drive_edge(1'b0, 1'b0, 9'h000);
        n_tests++; if (fetch_count_o !== 32'd6 || if_id_pc_o !== 9'h044) begin n_fail++; $display("FAIL flush_next: got cnt=%0d pc=%h want 6 044", fetch_count_o, if_id_pc_o); end
    endtask

    task automatic test_wrap();
        logic [8:0] exp_pc[4] = '{9'h1F8, 9'h1FC, 9'h000, 9'h004};
        drive_edge(1'b0, 1'b1, 9'h1F8);
        drive_edge(1'b0, 1'b0, 9'h000);
        for (int i = 0; i < 4; i++) begin
            drive_edge(1'b0, 1'b0, 9'h000);
            n_tests++;
            if (if_id_valid_o !== 1'b1 || if_id_pc_o !== exp_pc[i] || if_id_inst_o !== mem_word(exp_pc[i]) || fault_o !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap%0d: got v=%b pc=%h inst=%h fault=%b want 1 %h %h 0",
                         i, if_id_valid_o, if_id_pc_o, if_id_inst_o, fault_o, exp_pc[i], mem_word(exp_pc[i]));
            end
        end
    endtask

    task automatic test_random();
        logic       st;
        logic       fl;
        logic [8:0] tg;
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 9) < 3);
            fl = ($urandom_range(0, 9) == 0);
            tg = {7'($urandom_range(0, 127)), 2'b00};
            stall_i = st; flush_i = fl; target_i = tg;
            #1;
            n_tests++; if (imem_en_o !== m_en(st, fl)) begin n_fail++; $display("FAIL rand_en@%0d: got %b want %b", i, imem_en_o, m_en(st, fl)); end
            drive_edge(st, fl, tg);
            n_tests++;
            if (if_id_valid_o !== m_valid || if_id_inst_o !== m_inst() || (m_valid && if_id_pc_o !== m_id_pc)) begin
                n_fail++;
                $display("FAIL rand_ifid@%0d: got v=%b pc=%h inst=%h want v=%b pc=%h inst=%h",
                         i, if_id_valid_o, if_id_pc_o, if_id_inst_o, m_valid, m_id_pc, m_inst());
            end
            n_tests++;
            if (pc_o !== m_nxt || fetch_count_o !== m_count || fault_o !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_state@%0d: got pc=%h cnt=%0d fault=%b want %h %0d 0",
                         i, pc_o, fetch_count_o, fault_o, m_nxt, m_count);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [8:0] exp_pc[2] = '{9'h000, 9'h004};
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (if_id_valid_o !== 1'b0 || if_id_inst_o !== NOP || if_id_pc_o !== 9'h000 || pc_o !== 9'h000 ||
            fetch_count_o !== 32'd0 || imem_en_o !== 1'b1 || fault_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b inst=%h pc=%h pc_o=%h cnt=%0d en=%b fault=%b",
                     if_id_valid_o, if_id_inst_o, if_id_pc_o, pc_o, fetch_count_o, imem_en_o, fault_o);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive_edge(1'b0, 1'b0, 9'h000);
        n_tests++; if (if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL restart_edge1: got v=%b want 0", if_id_valid_o); end
        for (int i = 0; i < 2; i++) begin
            drive_edge(1'b0, 1'b0, 9'h000);
            n_tests++;
            if (if_id_valid_o !== 1'b1 || if_id_pc_o !== exp_pc[i] || if_id_inst_o !== mem_word(exp_pc[i])) begin
                n_fail++;
                $display("FAIL restart%0d: got v=%b pc=%h inst=%h want 1 %h %h",
                         i, if_id_valid_o, if_id_pc_o, if_id_inst_o, exp_pc[i], mem_word(exp_pc[i]));
            end
        end
    endtask

    task automatic test_fault();
        drive_edge(1'b0, 1'b1, 9'h042);
        n_tests++;
        if (fault_o !== 1'b1 || fault_pc_o !== 9'h042 || if_id_valid_o !== 1'b0 || if_id_inst_o !== NOP || imem_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_set: got f=%b fpc=%h v=%b inst=%h en=%b want 1 042 0 %h 0",
                     fault_o, fault_pc_o, if_id_valid_o, if_id_inst_o, imem_en_o, NOP);
        end
        drive_edge(1'b0, 1'b1, 9'h080);
        drive_edge(1'b0, 1'b1, 9'h0A1);
        drive_edge(1'b0, 1'b0, 9'h000);
        n_tests++;
        if (fault_o !== 1'b1 || fault_pc_o !== 9'h042 || pc_o !== m_nxt || fetch_count_o !== m_count ||
            imem_en_o !== 1'b0 || if_id_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_hold: got f=%b fpc=%h pc=%h cnt=%0d en=%b v=%b want 1 042 %h %0d 0 0",
                     fault_o, fault_pc_o, pc_o, fetch_count_o, imem_en_o, if_id_valid_o, m_nxt, m_count);
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (fault_o !== 1'b0 || fault_pc_o !== 9'h000 || imem_en_o !== 1'b1 || pc_o !== 9'h000) begin
            n_fail++;
            $display("FAIL fault_clear: got f=%b fpc=%h en=%b pc=%h want 0 000 1 000", fault_o, fault_pc_o, imem_en_o, pc_o);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_stall();
        test_flush_stall();
        test_wrap();
        test_random();
        test_async_reset();
        test_fault();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch (IF) stage plus IF/ID pipeline register for the pipelined RV32I core. It sits directly upstream of the decode stage. It owns the program counter, drives a synchronous-read instruction memory with read enable, absorbs hazard stalls and branch/jump redirects, and presents one instruction per cycle with a valid flag. It also detects misaligned redirect targets and counts delivered instructions.

## Interface
- `PC_W`, 9, byte-address width of PC and instruction memory (matches the `tb_pc` width)
- `INST_W`, 32, instruction width
- `RESET_PC`, 9'h000, first fetch address after reset
- `NOP`, 32'h0000_0013, instruction placed in IF/ID when empty (addi x0,x0,0)

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `stall_i`  in  1  hazard unit: hold PC and IF/ID this cycle
- `flush_i`  in  1  EX stage: taken branch/jump, redirect fetch
- `target_i`  in  PC_W  redirect byte address, sampled when `flush_i`=1
- `imem_addr_o`  out  PC_W  byte address to instruction memory
- `imem_en_o`  out  1  memory read enable; when 0, memory holds `imem_rdata_i`
- `imem_rdata_i`  in  INST_W  word at the address presented on the previous enabled edge
- `if_id_pc_o`  out  PC_W  PC of the delivered instruction
- `if_id_inst_o`  out  INST_W  delivered instruction
- `if_id_valid_o`  out  1  IF/ID holds a real instruction
- `pc_o`  out  PC_W  current issue PC, for test-bench trace
- `fault_o`  out  1  misaligned redirect seen; sticky
- `fault_pc_o`  out  PC_W  offending target
- `fetch_count_o`  out  32  number of instructions delivered

## Operation
- Registers:
  - `pc_q`: next address to issue.
  - `f_pc_q`, `f_valid_q`: address issued on the last enabled edge. `imem_rdata_i` currently carries its word.
  - IF/ID: `if_id_pc_o`, `if_id_inst_o`, `if_id_valid_o`.
- State machine:
  - START (reset state): exactly one cycle; issue `RESET_PC`, then go to RUN.
  - RUN: normal operation.
  - FAULT: terminal until reset.
- Combinational outputs:
  - `imem_addr_o` = `pc_q`
  - `pc_o` = `pc_q`
  - `imem_en_o` = 1 in START; in RUN = `flush_i` | ~`stall_i`; 0 in FAULT.
- RUN priority per edge:
  1. `flush_i` with `target_i[1:0]`≠0: go to FAULT, set `fault_o`=1, `fault_pc_o`=`target_i`, clear `f_valid_q` and IF/ID valid, set `if_id_inst_o`=NOP.
  2. `flush_i` aligned: `pc_q`←`target_i`, `f_valid_q`←0, `if_id_valid_o`←0, `if_id_inst_o`←NOP. This overrides `stall_i`.
  3. `stall_i`: hold every register.
  4. Advance: IF/ID←{`f_pc_q`, `imem_rdata_i`, `f_valid_q`}; `f_pc_q`←`pc_q`; `f_valid_q`←1; `pc_q`←`pc_q`+4.
- PC arithmetic is modulo 2^PC_W. 0x1FC+4 wraps to 0x000 with no fault.
- When IF/ID loads with valid=0, it loads `if_id_inst_o`=NOP.
- `fetch_count_o` increments on every edge where IF/ID loads valid=1. It wraps at 2^32 and holds during stall and FAULT.

## Timing
- Reset values:
  - `pc_q`=`RESET_PC`
  - `f_pc_q`=0, `f_valid_q`=0
  - `if_id_pc_o`=0, `if_id_inst_o`=NOP, `if_id_valid_o`=0
  - `fault_o`=0, `fault_pc_o`=0, `fetch_count_o`=0
  - state=START, so `imem_en_o`=1 during reset
- Reset asserted mid-operation clears all of the above immediately, with no clock needed.
- Latency: the first instruction appears in IF/ID after the 2nd rising edge following reset release (valid=1, pc=`RESET_PC`). After that, one instruction per edge.
- Redirect penalty: `if_id_valid_o`=0 for the 2 cycles after the flush edge. After the 3rd edge, IF/ID holds `target_i` with `pc_o`=`target_i`+8.
- Stall: outputs are frozen and `imem_en_o`=0, so the memory preserves the in-flight word. No instruction is lost or duplicated.

## Test plan
- Reset release, no stall/flush, memory word k = 0x100+k. After edges 2, 3, 4, IF/ID = (0x000, 0x100), (0x004, 0x101), (0x008, 0x102), all valid; `fetch_count_o`=3.
- Stall held 3 cycles at IF/ID pc=0x008. IF/ID, `pc_o` and count are frozen and `imem_en_o`=0. The first advance edge delivers pc=0x00C with no gap or repeat.
- Aligned flush to 0x040, with `stall_i`=1 on the same edge. Valid is 0 for 2 cycles with inst=NOP, then IF/ID = (0x040, mem[0x40]). Count resumes +1 per edge.
- Flush to 0x042. `fault_o`=1, `fault_pc_o`=0x042, valid=0, `imem_en_o`=0 permanently. Further flushes are ignored. Asserting `reset` clears the fault.
- Flush to 0x1F8, then run. IF/ID pcs are 0x1F8, 0x1FC, 0x000, 0x004; `fault_o` stays 0.
- Assert `reset` asynchronously mid-stream, between edges. Outputs go to reset values with no clock edge. After release, the sequence restarts at 0x000 with a 2-edge latency.
